// File: rtl/ifft_butterfly_pipe_if.sv
// Handshake and data bundle for the pipelined radix-2 IFFT butterfly.
// The source side (sequencer/testbench) uses master; the butterfly uses slave.
interface ifft_butterfly_pipe_if #(
  parameter int N = 3
);
  localparam int W = 1 << N;

  logic                in_valid;
  logic                in_ready;
  logic [1:0]          tw_idx;
  logic signed [W-1:0] in_1_r;
  logic signed [W-1:0] in_1_i;
  logic signed [W-1:0] in_2_r;
  logic signed [W-1:0] in_2_i;

  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_1_r;
  logic signed [W-1:0] out_1_i;
  logic signed [W-1:0] out_2_r;
  logic signed [W-1:0] out_2_i;

  modport master (
    output in_valid, tw_idx, in_1_r, in_1_i, in_2_r, in_2_i, out_ready,
    input  in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i
  );

  modport slave (
    input  in_valid, tw_idx, in_1_r, in_1_i, in_2_r, in_2_i, out_ready,
    output in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i
  );
endinterface

// File: rtl/ifft_butterfly_pipe.sv
// Three-stage radix-2 IFFT butterfly: out = (in_1 +/- W8^-k * in_2) / 2, saturated,
// with a single global stall enable driven by downstream backpressure.
module ifft_butterfly_pipe #(
  parameter int N = 3
) (
  input logic                   clk,
  input logic                   rst,
  ifft_butterfly_pipe_if.slave  bus
);
  localparam int W = 1 << N;
  localparam logic signed [W+1:0] sat_max = (W+2)'((1 << (W-1)) - 1);
  localparam logic signed [W+1:0] sat_min = (W+2)'(-(1 << (W-1)));

  function automatic logic signed [W+1:0] sx(input logic signed [W-1:0] v);
    return {{2{v[W-1]}}, v};
  endfunction

  // 1/sqrt(2) ~= 0.703125 as a shift-add; each shift floors toward -inf.
  function automatic logic signed [W+1:0] k_scale(input logic signed [W:0] x);
    logic signed [W+1:0] xe;
    xe = {x[W], x};
    return (xe >>> 1) + (xe >>> 3) + (xe >>> 4) + (xe >>> 6);
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [W+1:0] v);
    if (v > sat_max)      return sat_max[W-1:0];
    else if (v < sat_min) return sat_min[W-1:0];
    else                  return v[W-1:0];
  endfunction

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // S1 inputs: rotation helper terms formed before the first register.
  logic signed [W:0] d_in, s_in;
  assign d_in = {bus.in_2_r[W-1], bus.in_2_r} - {bus.in_2_i[W-1], bus.in_2_i};
  assign s_in = {bus.in_2_r[W-1], bus.in_2_r} + {bus.in_2_i[W-1], bus.in_2_i};

  logic                s1_valid;
  logic [1:0]          s1_k;
  logic signed [W-1:0] s1_a_r, s1_a_i, s1_b_r, s1_b_i;
  logic signed [W:0]   s1_d, s1_s;

  logic                s2_valid;
  logic signed [W-1:0] s2_a_r, s2_a_i;
  logic signed [W+1:0] s2_t_r, s2_t_i;

  logic signed [W+1:0] t_r, t_i;

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    t_r = sx(s1_b_r);
    t_i = sx(s1_b_i);
    case (s1_k)
      2'd1: begin
        t_r = k_scale(s1_d);
        t_i = k_scale(s1_s);
      end
      2'd2: begin
        t_r = -sx(s1_b_i);
        t_i = sx(s1_b_r);
      end
      2'd3: begin
        t_r = -k_scale(s1_s);
        t_i = k_scale(s1_d);
      end
      default: ;
    endcase
  end

  logic signed [W+1:0] sum_r, sum_i, dif_r, dif_i;
  assign sum_r = sx(s2_a_r) + s2_t_r;
  assign sum_i = sx(s2_a_i) + s2_t_i;
  assign dif_r = sx(s2_a_r) - s2_t_r;
  assign dif_i = sx(s2_a_i) - s2_t_i;

  // NOTE: data registers are reset along with the valids so outputs read zero during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_k          <= '0;
      s1_a_r        <= '0;
      s1_a_i        <= '0;
      s1_b_r        <= '0;
      s1_b_i        <= '0;
      s1_d          <= '0;
      s1_s          <= '0;
      s2_valid      <= 1'b0;
      s2_a_r        <= '0;
      s2_a_i        <= '0;
      s2_t_r        <= '0;
      s2_t_i        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_1_r   <= '0;
      bus.out_1_i   <= '0;
      bus.out_2_r   <= '0;
      bus.out_2_i   <= '0;
    end else if (adv) begin
      s1_valid      <= bus.in_valid;
      s1_k          <= bus.tw_idx;
      s1_a_r        <= bus.in_1_r;
      s1_a_i        <= bus.in_1_i;
      s1_b_r        <= bus.in_2_r;
      s1_b_i        <= bus.in_2_i;
      s1_d          <= d_in;
      s1_s          <= s_in;
      s2_valid      <= s1_valid;
      s2_a_r        <= s1_a_r;
      s2_a_i        <= s1_a_i;
      s2_t_r        <= t_r;
      s2_t_i        <= t_i;
      bus.out_valid <= s2_valid;
      bus.out_1_r   <= sat(sum_r >>> 1);
      bus.out_1_i   <= sat(sum_i >>> 1);
      bus.out_2_r   <= sat(dif_r >>> 1);
      bus.out_2_i   <= sat(dif_i >>> 1);
    end
  end
endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Self-checking bench for ifft_butterfly_pipe: directed butterflies, random full-rate
// and backpressured streams against an integer reference model, and mid-stream reset.
module tb_ifft_butterfly_pipe;
  typedef struct {
    int k;
    int a_r;
    int a_i;
    int b_r;
    int b_i;
  } vec_t;

  typedef struct {
    int o1_r;
    int o1_i;
    int o2_r;
    int o2_i;
    int cyc;
  } res_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;
  int   cyc;
  logic lat_check;
  logic stall_prev;
  int   prev_o[4];
  res_t sb[$];

  ifft_butterfly_pipe_if #(.N(3)) bus ();
  ifft_butterfly_pipe #(.N(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int k_ref(input int x);
    return (x >>> 1) + (x >>> 3) + (x >>> 4) + (x >>> 6);
  endfunction

  function automatic int clamp8(input int x);
    if (x > 127)  return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // Complex butterfly from the arithmetic definition: t = W8^-k * in_2, out = (in_1 +/- t) / 2.
  function automatic res_t ref_bfly(input vec_t v);
    res_t r;
    int tr, ti;
    case (v.k)
      0:       begin tr = v.b_r;               ti = v.b_i;               end
      1:       begin tr = k_ref(v.b_r - v.b_i); ti = k_ref(v.b_r + v.b_i); end
      2:       begin tr = -v.b_i;              ti = v.b_r;               end
      default: begin tr = -k_ref(v.b_r + v.b_i); ti = k_ref(v.b_r - v.b_i); end
    endcase
    r.o1_r = clamp8((v.a_r + tr) >>> 1);
    r.o1_i = clamp8((v.a_i + ti) >>> 1);
    r.o2_r = clamp8((v.a_r - tr) >>> 1);
    r.o2_i = clamp8((v.a_i - ti) >>> 1);
    r.cyc  = 0;
    return r;
  endfunction

  function automatic int rnd8();
    logic [7:0] u;
    u = 8'($urandom);
    return int'($signed(u));
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v.k   = int'($urandom_range(0, 3));
    v.a_r = rnd8();
    v.a_i = rnd8();
    v.b_r = rnd8();
    v.b_i = rnd8();
    return v;
  endfunction

  // One clock: drive inputs, settle, score both handshakes as they will occur at the
  // coming edge, then advance to just after that edge.
  task automatic drive_cycle(input logic iv, input vec_t v, input logic ordy,
                             input logic has_e, input res_t e, output logic acc);
    res_t x;
    bus.in_valid  = iv;
    bus.tw_idx    = 2'(v.k);
    bus.in_1_r    = 8'(v.a_r);
    bus.in_1_i    = 8'(v.a_i);
    bus.in_2_r    = 8'(v.b_r);
    bus.in_2_i    = 8'(v.b_i);
    bus.out_ready = ordy;
    #1;
    check("in_ready", int'(bus.in_ready), int'(!bus.out_valid || ordy));
    if (stall_prev) begin
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_o1_r", int'(bus.out_1_r), prev_o[0]);
      check("hold_o1_i", int'(bus.out_1_i), prev_o[1]);
      check("hold_o2_r", int'(bus.out_2_r), prev_o[2]);
      check("hold_o2_i", int'(bus.out_2_i), prev_o[3]);
    end
    if (bus.out_valid && ordy) begin
      if (sb.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        x = sb.pop_front();
        check("o1_r", int'(bus.out_1_r), x.o1_r);
        check("o1_i", int'(bus.out_1_i), x.o1_i);
        check("o2_r", int'(bus.out_2_r), x.o2_r);
        check("o2_i", int'(bus.out_2_i), x.o2_i);
        if (lat_check) check("latency", cyc - x.cyc, 3);
      end
    end
    acc = iv && bus.in_ready;
    if (acc) begin
      x     = has_e ? e : ref_bfly(v);
      x.cyc = cyc;
      sb.push_back(x);
    end
    stall_prev = bus.out_valid && !ordy;
    prev_o[0]  = int'(bus.out_1_r);
    prev_o[1]  = int'(bus.out_1_i);
    prev_o[2]  = int'(bus.out_2_r);
    prev_o[3]  = int'(bus.out_2_i);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
    check({tag, "_o1_r"}, int'(bus.out_1_r), 0);
    check({tag, "_o1_i"}, int'(bus.out_1_i), 0);
    check({tag, "_o2_r"}, int'(bus.out_2_r), 0);
    check({tag, "_o2_i"}, int'(bus.out_2_i), 0);
  endtask

  vec_t dir_v[5];
  res_t dir_e[5];
  vec_t bp_v[8];
  vec_t idle;
  res_t none;
  logic acc;
  int   taken;

  initial begin
    n_vec = 0; n_fail = 0; cyc = 0;
    lat_check = 1'b0; stall_prev = 1'b0;
    idle = '{0, 0, 0, 0, 0};
    none = '{0, 0, 0, 0, 0};
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.tw_idx = '0; bus.out_ready = 1'b1;
    bus.in_1_r = '0; bus.in_1_i = '0; bus.in_2_r = '0; bus.in_2_i = '0;
    #1;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed butterflies with hand-derived results.
    dir_v[0] = '{0, 40, 20, 10, -6};      dir_e[0] = '{25, 7, 15, 13, 0};
    dir_v[1] = '{1, 0, 0, 64, 0};         dir_e[1] = '{22, 22, -23, -23, 0};
    dir_v[2] = '{2, 10, 10, 4, 6};        dir_e[2] = '{2, 7, 8, 3, 0};
    dir_v[3] = '{1, 127, 127, 127, -128}; dir_e[3] = '{127, 61, -25, 65, 0};
    dir_v[4] = '{3, -128, -128, -128, 127}; dir_e[4] = '{-62, -128, -66, 26, 0};
    lat_check = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, dir_v[i], 1'b1, 1'b1, dir_e[i], acc);
      check("dir_accept", int'(acc), 1);
      repeat (3) drive_cycle(1'b0, idle, 1'b1, 1'b0, none, acc);
    end
    check("dir_drained", sb.size(), 0);

    // Random back-to-back stream at full rate.
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b0, none, acc);
      check("full_rate_accept", int'(acc), 1);
    end
    repeat (4) drive_cycle(1'b0, idle, 1'b1, 1'b0, none, acc);
    check("full_rate_drained", sb.size(), 0);

    // Backpressure: continuous valid, 5 stalled cycles, then random ready.
    lat_check = 1'b0;
    for (int i = 0; i < 8; i++) bp_v[i] = rnd_vec();
    taken = 0;
    for (int c = 0; c < 400 && (taken < 8 || sb.size() > 0); c++) begin
      drive_cycle(taken < 8, bp_v[(taken < 8) ? taken : 7],
                  (c < 5) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0, none, acc);
      if (c == 4) check("stalled_in_ready", int'(bus.in_ready), 0);
      if (acc) taken++;
    end
    check("bp_accepted", taken, 8);
    check("bp_drained", sb.size(), 0);

    // Reset with three vectors in flight; nothing may emerge afterwards.
    lat_check = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, rnd_vec(), 1'b1, 1'b0, none, acc);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_state("mid_rst");
    sb.delete();
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, idle, 1'b1, 1'b0, none, acc);
      check("no_stale_valid", int'(bus.out_valid), 0);
    end
    drive_cycle(1'b1, dir_v[2], 1'b1, 1'b1, dir_e[2], acc);
    repeat (3) drive_cycle(1'b0, idle, 1'b1, 1'b0, none, acc);
    check("post_rst_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
